// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DMEM_BYTE_SWAP_EN (byte-reversed storage format).
package dmem_pkg;

  localparam int unsigned DM_WIDTH      = 64;
  localparam int unsigned DM_ADDR_WIDTH = 64;
  localparam int unsigned DM_DEPTH_LOG2 = 10;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

  // Source of the read-data output between read completions.
  typedef enum logic [1:0] {
    OUT_ZERO = 2'd0,
    OUT_FWD  = 2'd1,
    OUT_ARR  = 2'd2
  } dm_out_sel_e;

  // Conversion between bus order and storage order; self-inverse.
  function automatic logic [DM_WIDTH-1:0] dm_store_fmt(input logic [DM_WIDTH-1:0] d);
    logic [DM_WIDTH-1:0] r;
`ifdef DMEM_BYTE_SWAP_EN
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

endpackage

// File: rtl/dmem_array_1rw.sv
// Single-port synchronous RAM: one read or write per cycle, registered read data.
module dmem_array_1rw
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DM_WIDTH-1:0]   wdata,
  output logic [DM_WIDTH-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DM_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clear-on-reset FSM, posted-write store buffer with
// read forwarding, address checking. Optional macro: DMEM_BYTE_SWAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_dm_cs,
  input  logic                     i_dm_rw,
  input  logic [DM_ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DM_WIDTH-1:0]      i_dm_data,
  output logic [DM_WIDTH-1:0]      o_dm_data,
  output logic                     o_dm_rvalid,
  output logic                     o_dm_ready,
  output logic                     o_dm_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  dm_state_e             state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  sb_valid;
  logic [DEPTH_LOG2-1:0] sb_idx;
  logic [DM_WIDTH-1:0]   sb_data;
  logic [DM_WIDTH-1:0]   fwd_data;
  dm_out_sel_e           out_sel;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_bad;
  logic                  accept;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  fwd_hit;
  logic                  commit;

  logic                  arr_en;
  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [DM_WIDTH-1:0]   arr_wdata;
  logic [DM_WIDTH-1:0]   arr_rdata;

  assign idx      = i_dm_addr[DEPTH_LOG2+2:3];
  assign addr_bad = (|i_dm_addr[2:0]) | (|i_dm_addr[DM_ADDR_WIDTH-1:DEPTH_LOG2+3]);
  assign accept   = i_dm_cs & o_dm_ready;
  assign rd_ok    = accept & ~i_dm_rw & ~addr_bad;
  assign wr_ok    = accept &  i_dm_rw & ~addr_bad;
  assign fwd_hit  = sb_valid & (sb_idx == idx);
  // The buffer drains whenever the single array port is not claimed by a read.
  assign commit   = (state == READY) & sb_valid & ~rd_ok;

  // Array port arbitration: clear sweep, then reads, then buffer commits.
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = idx;
    arr_wdata = sb_data;
    if (state == CLEAR) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_addr  = clr_cnt;
      arr_wdata = '0;
    end else if (rd_ok) begin
      arr_en    = 1'b1;
    end else if (commit) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_addr  = sb_idx;
    end
  end

  dmem_array_1rw #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (i_clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      sb_valid    <= 1'b0;
      sb_idx      <= '0;
      sb_data     <= '0;
      fwd_data    <= '0;
      out_sel     <= OUT_ZERO;
      o_dm_rvalid <= 1'b0;
      o_dm_ready  <= 1'b0;
      o_dm_err    <= 1'b0;
    end else begin
      o_dm_rvalid <= accept & ~i_dm_rw;
      o_dm_err    <= accept & addr_bad;

      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
          if (clr_cnt == DEPTH_LOG2'(DEPTH - 1)) begin
            state      <= READY;
            o_dm_ready <= 1'b1;
          end
        end
        READY: ;
        default: state <= CLEAR;
      endcase

      if (commit) begin
        sb_valid <= 1'b0;
      end
      if (wr_ok) begin
        sb_valid <= 1'b1;
        sb_idx   <= idx;
        sb_data  <= dm_store_fmt(i_dm_data);
      end

      // Remember where the completed read's data lives so the output holds it.
      if (accept & ~i_dm_rw) begin
        if (addr_bad) begin
          out_sel <= OUT_ZERO;
        end else if (fwd_hit) begin
          out_sel  <= OUT_FWD;
          fwd_data <= sb_data;
        end else begin
          out_sel <= OUT_ARR;
        end
      end
    end
  end

  always_comb begin
    o_dm_data = '0;
    case (out_sel)
      OUT_FWD: o_dm_data = dm_store_fmt(fwd_data);
      OUT_ARR: o_dm_data = dm_store_fmt(arr_rdata);
      default: o_dm_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH_LOG2=4): directed scenarios plus
// randomized traffic against a plain word-array memory model.
module tb_dmem_responder;

  localparam int unsigned DL2 = 4;
  localparam int unsigned NW  = 16;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        rw;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rvalid;
  logic        ready;
  logic        err;

  typedef struct {
    bit          rv;
    bit          er;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model[NW];
  logic [63:0] last_data;
  int          n_checks;
  int          n_errors;

  dmem_responder #(.DEPTH_LOG2(DL2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_dm_cs    (cs),
    .i_dm_rw    (rw),
    .i_dm_addr  (addr),
    .i_dm_data  (wdata),
    .o_dm_data  (rdata),
    .o_dm_rvalid(rvalid),
    .o_dm_ready (ready),
    .o_dm_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals a response.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      last_data = '0;
      check("reset_outputs", {rdata, rvalid, ready, err}, '0);
    end else if (rvalid || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", {62'd0, rvalid, err}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rvalid", 64'(rvalid), 64'(e.rv));
        check("err", 64'(err), 64'(e.er));
        if (e.rv) begin
          check("rdata", rdata, e.data);
          last_data = e.data;
        end
      end
    end else begin
      check("hold_data", rdata, last_data);
    end
  end

  // One cycle of stimulus; the model decides the response from memory semantics.
  task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d);
    bit bad;
    int wi;
    cs    = 1'b1;
    rw    = w;
    addr  = a;
    wdata = d;
    if (ready) begin
      bad = (a % 8 != 0) || (a >= 64'(NW * 8));
      wi  = int'(a / 8);
      if (bad) begin
        exp_q.push_back('{rv: !w, er: 1'b1, data: 64'd0});
      end else if (w) begin
        model[wi] = d;
      end else begin
        exp_q.push_back('{rv: 1'b1, er: 1'b0, data: model[wi]});
      end
    end
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    cs = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    cs  = 1'b0;
    rst = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int i = 0; i < int'(NW); i++) model[i] = '0;
  endtask

  // Counts edges until ready rises; optionally hammers requests during the clear.
  task automatic wait_ready(input bit poke);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      if (poke) begin
        cs   = 1'b1;
        rw   = n[0];
        addr = (n % 3 == 0) ? 64'h4 : 64'h8;
      end
      @(posedge clk); #1;
      n++;
    end
    cs = 1'b0;
    check("clear_cycles", 64'(n), 64'd16);
  endtask

  task automatic read_all();
    for (int i = 0; i < int'(NW); i++) issue(1'b0, 64'(i * 8), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    last_data = '0;
    rst   = 1'b0;
    cs    = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < int'(NW); i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ready(1'b1);
    read_all();

    // Write then immediate read of the same word: served from the store buffer.
    issue(1'b1, 64'h18, 64'h1122334455667788);
    issue(1'b0, 64'h18, '0);
    idle(2);

    issue(1'b1, 64'h00, 64'hA);
    issue(1'b1, 64'h08, 64'hB);
    issue(1'b1, 64'h10, 64'hC);
    issue(1'b0, 64'h00, '0);
    issue(1'b0, 64'h08, '0);
    issue(1'b0, 64'h10, '0);

    // Misaligned and out-of-range accesses leave storage untouched.
    issue(1'b0, 64'h04, '0);
    issue(1'b0, 64'h80, '0);
    issue(1'b1, 64'h81, 64'hDEAD);
    issue(1'b1, 64'h8000_0000_0000_0000, 64'hBEEF);
    issue(1'b0, 64'h18, '0);
    issue(1'b0, 64'h00, '0);
    idle(2);

    for (int k = 0; k < 600; k++) begin
      int unsigned sel;
      int unsigned word;
      logic [63:0] a;
      sel  = $urandom_range(0, 15);
      word = (sel < 8) ? $urandom_range(0, 3) : $urandom_range(0, NW - 1);
      a    = 64'(word * 8);
      if (sel == 15) a = a | 64'($urandom_range(1, 7));
      if (sel == 14) a = a | (64'd1 << $urandom_range(7, 63));
      if (sel == 13) idle(1);
      else issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    idle(2);
    read_all();

    // Buffered write still pending when reset hits must be lost.
    issue(1'b1, 64'h08, 64'h5);
    repeat (4) issue(1'b0, 64'h10, '0);
    do_reset(2);
    wait_ready(1'b0);
    issue(1'b0, 64'h08, '0);
    idle(1);

    // Reset during the clear sweep restarts it from word 0.
    do_reset(2);
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("ready_mid_clear", 64'(ready), 64'd0);
    do_reset(2);
    wait_ready(1'b1);
    read_all();
    idle(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
